// File: rtl/chicken_datapath.sv
// chicken_datapath
//   Game datapath for the Chicken Cha-Cha-Cha board game. It is the responder
//   half of the game control interface. It decodes the controller state code M
//   and player count N, holds the board, card and chicken state, and returns
//   the c / go / win flags that drive the controller's transitions.
//
// Handshake: there is no valid/ready pair. The controller's state code M is
//   treated as a one-hot command per cycle. A card capture happens on the edge
//   where M == WAIT_KEY and key != 0. The resulting go/win flags are registered
//   on that edge, so they are stable throughout the following JUDGE and MOVE
//   cycles.
//
// Ports:
//   clk           in   system clock
//   rst           in   synchronous reset, active-low
//   start         in   start button level (echoed to c while IDLE)
//   key           in   card select, 0 = no press, 1..CARDS = card
//   M             in   controller state code
//   N             in   player count (0 = 4 players, 1 is treated as 2)
//   c             out  start request to the controller
//   go            out  last captured card matched the target tile
//   win           out  current player has won
//   cur_player    out  player whose turn it is
//   pos_bus       out  chicken positions, player p at [p*PW +: PW]
//   target_animal out  animal on the tile ahead of the current chicken (comb)

module chicken_datapath #(
  parameter int unsigned BOARD_LEN = 16,
  parameter int unsigned CARDS     = 12,
  parameter int unsigned ANIMALS   = 4,
  parameter int unsigned WIN_STEPS = 16,
  localparam int unsigned PW = $clog2(BOARD_LEN),
  localparam int unsigned SW = $clog2(WIN_STEPS) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      key,
  input  logic [2:0]      M,
  input  logic [1:0]      N,
  output logic            c,
  output logic            go,
  output logic            win,
  output logic [1:0]      cur_player,
  output logic [4*PW-1:0] pos_bus,
  output logic [1:0]      target_animal
);

  // Decoded controller state; kept as a named signal so checkers can bind
  // to it directly.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_PLAYERS  = 3'b001,
    ST_SETUP    = 3'b010,
    ST_WAIT_KEY = 3'b011,
    ST_JUDGE    = 3'b100,
    ST_PASS     = 3'b101,
    ST_MOVE     = 3'b110,
    ST_DONE     = 3'b111
  } state_t;

  localparam logic [3:0]    CARDS_K = 4'(CARDS);
  localparam logic [SW-1:0] WIN_K   = SW'(WIN_STEPS);

  state_t m_state;
  assign m_state = state_t'(M);

  logic [PW-1:0] pos   [4];
  logic [SW-1:0] steps [4];

  // Fixed animal maps; no shuffling.
  function automatic logic [1:0] tile_animal(input logic [PW-1:0] t);
    return 2'((32'(t) * 32'd3) % ANIMALS);
  endfunction

  function automatic logic [1:0] card_animal(input logic [3:0] k);
    return 2'((32'(k) - 32'd1) % ANIMALS);
  endfunction

  function automatic logic [PW-1:0] home_pos(input int p);
    return PW'((32'(p) * BOARD_LEN) / 32'd4);
  endfunction

  logic [PW-1:0] cur_pos;
  logic [PW-1:0] next_tile;
  logic [SW-1:0] cur_steps;
  logic          key_valid;
  logic          match;
  logic          win_next;
  logic [2:0]    players;
  logic [1:0]    next_player;

  // BOARD_LEN is a power of two, so the PW-bit add wraps the ring for free.
  assign cur_pos       = pos[cur_player];
  assign next_tile     = cur_pos + PW'(1);
  assign cur_steps     = steps[cur_player];
  assign target_animal = tile_animal(next_tile);

  assign key_valid = (key != 4'd0) && (key <= CARDS_K);
  assign match     = key_valid && (card_animal(key) == target_animal);
  assign win_next  = match && ((cur_steps + SW'(1)) == WIN_K);

  always_comb begin
    players = 3'd2;
    case (N)
      2'd0:    players = 3'd4;
      2'd1:    players = 3'd2;
      2'd2:    players = 3'd2;
      default: players = 3'd3;
    endcase
  end

  // Using >= rather than == also recovers a cur_player that is out of range
  // after N was lowered mid-game.
  always_comb begin
    next_player = cur_player + 2'd1;
    if (({1'b0, cur_player} + 3'd1) >= players) next_player = 2'd0;
  end

  always_comb begin
    pos_bus = '0;
    for (int p = 0; p < 4; p++) pos_bus[p*PW +: PW] = pos[p];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      c          <= 1'b0;
      go         <= 1'b0;
      win        <= 1'b0;
      cur_player <= 2'd0;
      for (int p = 0; p < 4; p++) begin
        pos[p]   <= home_pos(p);
        steps[p] <= '0;
      end
    end else begin
      c <= (m_state == ST_IDLE) ? start : 1'b0;
      case (m_state)
        ST_SETUP: begin
          for (int p = 0; p < 4; p++) begin
            pos[p]   <= home_pos(p);
            steps[p] <= '0;
          end
          cur_player <= 2'd0;
          go         <= 1'b0;
          win        <= 1'b0;
        end
        ST_WAIT_KEY: begin
          // Capture edge: the controller moves to JUDGE on this same edge.
          if (key != 4'd0) begin
            go  <= match;
            win <= win_next;
          end
        end
        ST_PASS: begin
          cur_player <= next_player;
          go         <= 1'b0;
        end
        ST_MOVE: begin
          pos[cur_player] <= cur_pos + PW'(1);
          if (cur_steps != WIN_K) steps[cur_player] <= cur_steps + SW'(1);
          go <= 1'b0;
        end
        default: begin
          // IDLE, PLAYERS, JUDGE and DONE hold all game state.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chicken_datapath.sv
// tb_chicken_datapath
//   Directed bench for chicken_datapath. Two instances share every input:
//   dut_a with default parameters and dut_b with WIN_STEPS=2 for the short
//   win scenario. Stimulus pushes expected values tagged with the cycle they
//   belong to; a monitor on the falling edge pops and compares them.

module tb_chicken_datapath;

  localparam int PW = 4;

  localparam logic [2:0] S_IDLE  = 3'b000;
  localparam logic [2:0] S_SETUP = 3'b010;
  localparam logic [2:0] S_WAIT  = 3'b011;
  localparam logic [2:0] S_JUDGE = 3'b100;
  localparam logic [2:0] S_PASS  = 3'b101;
  localparam logic [2:0] S_MOVE  = 3'b110;
  localparam logic [2:0] S_DONE  = 3'b111;

  localparam int SEL_C     = 0;
  localparam int SEL_GO    = 1;
  localparam int SEL_WIN   = 2;
  localparam int SEL_CUR   = 3;
  localparam int SEL_POS   = 4;
  localparam int SEL_TGT   = 5;
  localparam int SEL_B_WIN = 6;
  localparam int SEL_B_POS = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [3:0] key;
  logic [2:0] M;
  logic [1:0] N;

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  logic            a_c, a_go, a_win;
  logic [1:0]      a_cur, a_tgt;
  logic [4*PW-1:0] a_pos;
  logic            b_c, b_go, b_win;
  logic [1:0]      b_cur, b_tgt;
  logic [4*PW-1:0] b_pos;

  chicken_datapath dut_a (
    .clk(clk), .rst(rst), .start(start), .key(key), .M(M), .N(N),
    .c(a_c), .go(a_go), .win(a_win), .cur_player(a_cur),
    .pos_bus(a_pos), .target_animal(a_tgt)
  );

  chicken_datapath #(.WIN_STEPS(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .key(key), .M(M), .N(N),
    .c(b_c), .go(b_go), .win(b_win), .cur_player(b_cur),
    .pos_bus(b_pos), .target_animal(b_tgt)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    int          cyc;
    int          sel;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic expect_sig(input int sel, input logic [15:0] val, input string name);
    exp_t e;
    e.cyc  = cyc_cnt;
    e.sel  = sel;
    e.val  = val;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic expect_all(input string tag, input logic c_e, input logic go_e,
                            input logic win_e, input logic [1:0] cur_e,
                            input logic [15:0] pos_e, input logic [1:0] tgt_e);
    expect_sig(SEL_C,   {15'd0, c_e},   {tag, ".c"});
    expect_sig(SEL_GO,  {15'd0, go_e},  {tag, ".go"});
    expect_sig(SEL_WIN, {15'd0, win_e}, {tag, ".win"});
    expect_sig(SEL_CUR, {14'd0, cur_e}, {tag, ".cur"});
    expect_sig(SEL_POS, pos_e,          {tag, ".pos"});
    expect_sig(SEL_TGT, {14'd0, tgt_e}, {tag, ".tgt"});
  endtask

  function automatic logic [15:0] actual(input int sel);
    case (sel)
      SEL_C:     return {15'd0, a_c};
      SEL_GO:    return {15'd0, a_go};
      SEL_WIN:   return {15'd0, a_win};
      SEL_CUR:   return {14'd0, a_cur};
      SEL_POS:   return a_pos;
      SEL_TGT:   return {14'd0, a_tgt};
      SEL_B_WIN: return {15'd0, b_win};
      default:   return b_pos;
    endcase
  endfunction

  initial begin : monitor
    exp_t        e;
    logic [15:0] act;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
        e   = exp_q.pop_front();
        act = actual(e.sel);
        n_vec++;
        if (e.cyc != cyc_cnt) begin
          n_fail++;
          $display("FAIL %s: sample missed (cycle %0d, now %0d)", e.name, e.cyc, cyc_cnt);
        end else if (act !== e.val) begin
          n_fail++;
          $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic [2:0] m, input logic [3:0] k,
                      input logic s, input logic r);
    M = m; key = k; start = s; rst = r;
    @(posedge clk);
    #1;
  endtask

  // Animal of the tile ahead of a chicken at position p.
  function automatic logic [1:0] tgt_of(input int p);
    return 2'((3 * ((p + 1) % 16)) % 4);
  endfunction

  initial begin : stimulus
    M = S_IDLE; key = 4'd0; start = 1'b0; rst = 1'b0; N = 2'd2;

    // 1. reset, then start echoed to c
    step(S_IDLE, 4'd0, 1'b0, 1'b0);
    step(S_IDLE, 4'd0, 1'b0, 1'b0);
    expect_all("reset", 1'b0, 1'b0, 1'b0, 2'd0, 16'hC840, 2'd3);
    step(S_IDLE, 4'd0, 1'b1, 1'b1);
    expect_sig(SEL_C, 16'd1, "idle_c");

    // 2. first matched card and move
    step(S_SETUP, 4'd0, 1'b1, 1'b1);
    expect_all("setup", 1'b0, 1'b0, 1'b0, 2'd0, 16'hC840, 2'd3);
    step(S_WAIT, 4'd4, 1'b0, 1'b1);
    expect_sig(SEL_GO, 16'd1, "cap4.go");
    expect_sig(SEL_WIN, 16'd0, "cap4.win");
    step(S_JUDGE, 4'd0, 1'b0, 1'b1);
    expect_sig(SEL_GO, 16'd1, "judge4.go");
    step(S_MOVE, 4'd0, 1'b0, 1'b1);
    expect_all("move1", 1'b0, 1'b0, 1'b0, 2'd0, 16'hC841, 2'd2);

    // 3. mismatch, then PASS rotation with 2 and 4 players
    step(S_WAIT, 4'd1, 1'b0, 1'b1);
    expect_sig(SEL_GO, 16'd0, "cap1.go");
    step(S_JUDGE, 4'd0, 1'b0, 1'b1);
    step(S_PASS, 4'd0, 1'b0, 1'b1);
    expect_sig(SEL_CUR, 16'd1, "pass2a.cur");
    expect_sig(SEL_GO, 16'd0, "pass2a.go");
    expect_sig(SEL_TGT, 16'd3, "pass2a.tgt");
    step(S_PASS, 4'd0, 1'b0, 1'b1);
    expect_sig(SEL_CUR, 16'd0, "pass2b.cur");
    N = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      step(S_PASS, 4'd0, 1'b0, 1'b1);
      expect_sig(SEL_CUR, 16'(i % 4), $sformatf("pass4_%0d.cur", i));
    end

    // 4. short game on dut_b (WIN_STEPS=2): second match wins
    step(S_WAIT, 4'd3, 1'b0, 1'b1);
    expect_sig(SEL_B_WIN, 16'd1, "b_cap3.win");
    expect_sig(SEL_GO, 16'd1, "a_cap3.go");
    expect_sig(SEL_WIN, 16'd0, "a_cap3.win");
    step(S_JUDGE, 4'd0, 1'b0, 1'b1);
    expect_sig(SEL_B_WIN, 16'd1, "b_judge.win");
    step(S_MOVE, 4'd0, 1'b0, 1'b1);
    expect_sig(SEL_B_WIN, 16'd1, "b_move.win");
    expect_sig(SEL_B_POS, 16'hC842, "b_move.pos");
    step(S_DONE, 4'd0, 1'b0, 1'b1);
    step(S_DONE, 4'd0, 1'b0, 1'b1);
    expect_sig(SEL_B_WIN, 16'd1, "b_done.win");
    expect_sig(SEL_B_POS, 16'hC842, "b_done.pos");

    // 5. full 16-move game on dut_a with wrap and out-of-range key
    step(S_SETUP, 4'd0, 1'b0, 1'b1);
    expect_sig(SEL_B_WIN, 16'd0, "b_setup.win");
    expect_sig(SEL_POS, 16'hC840, "setup2.pos");
    for (int i = 0; i < 16; i++) begin
      step(S_WAIT, 4'(tgt_of(i)) + 4'd1, 1'b0, 1'b1);
      expect_sig(SEL_GO, 16'd1, $sformatf("run%0d.go", i));
      expect_sig(SEL_WIN, (i == 15) ? 16'd1 : 16'd0, $sformatf("run%0d.win", i));
      if (i == 5) begin
        step(S_WAIT, 4'd14, 1'b0, 1'b1);
        expect_sig(SEL_GO, 16'd0, "key14.go");
        expect_sig(SEL_WIN, 16'd0, "key14.win");
        step(S_WAIT, 4'(tgt_of(i)) + 4'd5, 1'b0, 1'b1);
        expect_sig(SEL_GO, 16'd1, "recap.go");
      end
      step(S_JUDGE, 4'd0, 1'b0, 1'b1);
      step(S_MOVE, 4'd0, 1'b0, 1'b1);
      expect_sig(SEL_POS, 16'hC840 | 16'((i + 1) % 16), $sformatf("run%0d.pos", i));
      expect_sig(SEL_TGT, 16'(tgt_of((i + 1) % 16)), $sformatf("run%0d.tgt", i));
    end
    expect_sig(SEL_WIN, 16'd1, "run_end.win");
    step(S_DONE, 4'd0, 1'b0, 1'b1);
    step(S_DONE, 4'd0, 1'b0, 1'b1);
    expect_all("done", 1'b0, 1'b0, 1'b1, 2'd0, 16'hC840, 2'd3);

    // 6. reset overrides a MOVE
    step(S_PASS, 4'd0, 1'b0, 1'b1);
    expect_sig(SEL_CUR, 16'd1, "pre_rst.cur");
    expect_sig(SEL_WIN, 16'd1, "pre_rst.win");
    step(S_MOVE, 4'd0, 1'b1, 1'b0);
    expect_all("rst_move", 1'b0, 1'b0, 1'b0, 2'd0, 16'hC840, 2'd3);
    step(S_IDLE, 4'd0, 1'b0, 1'b1);
    expect_sig(SEL_C, 16'd0, "idle_c0");
    step(S_IDLE, 4'd0, 1'b1, 1'b1);
    expect_sig(SEL_C, 16'd1, "idle_c1");

    // drain the scoreboard with a bounded wait
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_fail += exp_q.size();
      $display("FAIL drain: %0d expectations never sampled, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/chicken_datapath.md
Name: chicken_datapath

Overview:
- Game datapath for the Chicken Cha-Cha-Cha board game; the responder half of the game control interface.
- Decodes the controller's state code M and player count N. Holds the board, card and chicken state.
- Returns the handshake flags c (start), go (card matched) and win (game over) that drive the controller's transitions.
- Sits beside the game control unit; positions and current player also drive display logic.

Parameters:
BOARD_LEN, 16, ring tiles; power of two, position width PW = log2(BOARD_LEN)
CARDS, 12, face-down cards selectable via key 1..CARDS
ANIMALS, 4, animal kinds; tile i shows (3*i) mod ANIMALS, card k shows (k-1) mod ANIMALS
WIN_STEPS, 16, successful moves a chicken needs to win

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (rst==0 resets on the clk edge)
start  in  1  start button level
key  in  4  card select; 0 = no press, 1..CARDS = card
M  in  3  controller state code
N  in  2  player count; 2 or 3 = that many, 0 = 4 players, 1 treated as 2
c  out  1  start request to controller
go  out  1  last captured card matched the target tile
win  out  1  current player has won
cur_player  out  2  player whose turn it is
pos_bus  out  4*PW  chicken positions, player p at bits [p*PW +: PW]
target_animal  out  2  animal of tile ahead of the current chicken

Behaviour:
- Every output is registered, except target_animal, which is combinational from pos[cur_player]+1 mod BOARD_LEN.
- Reset (rst==0): c=0, go=0, win=0, cur_player=0, pos[p]=p*BOARD_LEN/4, steps[p]=0. A reset in any state overrides everything else.
- State codes decoded: 000 IDLE, 001 PLAYERS, 010 SETUP, 011 WAIT_KEY, 100 JUDGE, 101 PASS, 110 MOVE, 111 DONE.
- IDLE: c <= start. Any other state: c <= 0.
- SETUP (one cycle): pos[p] <= p*BOARD_LEN/4, steps <= 0, cur_player <= 0, go <= 0, win <= 0.
- WAIT_KEY with key != 0 (the capture edge; the controller reaches JUDGE on the same edge):
  - go <= (1 <= key <= CARDS) && card_animal(key) == tile_animal(pos[cur]+1 mod BOARD_LEN).
  - win <= that match && steps[cur]+1 == WIN_STEPS.
  - Both are therefore valid throughout JUDGE and MOVE.
  - key 13..15 gives go=0 and win=0.
- WAIT_KEY with key == 0: go and win hold.
- JUDGE: no state change.
- PASS (one cycle):
  - cur_player <= (cur_player+1 == players) ? 0 : cur_player+1, where players = 4 if N==0, 2 if N==1, else N.
  - go <= 0.
- MOVE (one cycle):
  - pos[cur] <= pos[cur]+1, wrapping BOARD_LEN-1 -> 0.
  - steps[cur] <= steps[cur]+1, saturating at WIN_STEPS.
  - go <= 0. cur_player unchanged; the same player plays again.
- DONE: all state holds and win stays 1 until reset or SETUP.
- Chickens may share a tile; there is no collision logic.
- Card and tile animal maps are fixed functions with no shuffling.
- N is sampled only in PASS. A change of N mid-game takes effect at the next PASS.
- If cur_player >= players (N lowered mid-game), PASS wraps cur_player to 0.
- steps width = log2(WIN_STEPS)+1.

Test Plan:
1. rst=0 for 2 clk, then rst=1 with M=000, start=1 -> c=1 next edge. Reset values: pos_bus = {12,8,4,0}, go=0, win=0, cur_player=0.
2. SETUP, then M=011 with key=4 (card animal 3; target tile 1 animal 3) -> go=1, win=0 during JUDGE. MOVE -> pos[0]=1, steps[0]=1, cur_player=0, target_animal=2.
3. N=2, M=011 with key=1 (animal 0 vs target 3), then JUDGE, then PASS -> go=0 and cur_player=1. A second PASS -> cur_player=0. Repeat with N=0 -> cur_player cycles 0,1,2,3,0.
4. WIN_STEPS=2: key=4 then MOVE, then key=3 (animal 2 vs tile 2 animal 2) -> win=1 during JUDGE and MOVE. win holds in DONE; pos[0]=2.
5. Wrap: force pos[0]=15 via 15 matched moves with WIN_STEPS=16 -> the 16th match sets win=1 and pos[0] wraps to 0. Also key=14 -> go=0.
6. Assert rst=0 during MOVE -> next edge all reset values. A MOVE update must not take effect in that cycle.
